// File: rtl/vector_scheduler_if.sv
// Scheduler <-> vector table / stimulus lanes bundle.
// master: scheduler side; slave: table RAM and lane side.
interface vector_scheduler_if #(
  parameter int MAX_PARALLEL = 4,
  parameter int VEC_W        = 5
);
  logic                    tbl_rd_en;
  logic [VEC_W-1:0]        tbl_rd_addr;
  logic [MAX_PARALLEL-1:0] tbl_rd_data;
  logic [MAX_PARALLEL-1:0] lane_start;
  logic [MAX_PARALLEL-1:0] lane_abort;
  logic [MAX_PARALLEL-1:0] lane_done;
  logic [MAX_PARALLEL-1:0] lane_error;

  modport master (
    output tbl_rd_en, tbl_rd_addr,
    output lane_start, lane_abort,
    input  tbl_rd_data, lane_done, lane_error
  );

  modport slave (
    input  tbl_rd_en, tbl_rd_addr,
    input  lane_start, lane_abort,
    output tbl_rd_data, lane_done, lane_error
  );
endinterface

// File: rtl/vector_scheduler.sv
// Test-vector sequencer: fetch lane mask, launch lanes, retire on first done.
// Ports: ap_clk/ap_rst_n, start/vector_count, tbl (table+lanes), status outs.
module vector_scheduler #(
  parameter int MAX_PARALLEL   = 4,
  parameter int MAX_VECTORS    = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int VEC_W = $clog2(MAX_VECTORS + 1)
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    start,
  input  logic [VEC_W-1:0]        vector_count,
  vector_scheduler_if.master      tbl,
  output logic                    busy,
  output logic                    vector_done,
  output logic [VEC_W-1:0]        vector_idx,
  output logic                    vector_err,
  output logic                    suite_done,
  output logic                    suite_pass,
  output logic [MAX_PARALLEL-1:0] error_lanes
);

  localparam int WD_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    Idle, Fetch, WaitRd, Launch, Run, Drain, Done
  } state_t;

  state_t state, nextState;

  logic [VEC_W-1:0]        cnt;
  logic [VEC_W-1:0]        clampedCount;
  logic [MAX_PARALLEL-1:0] activeMask;
  logic [MAX_PARALLEL-1:0] finished;
  logic [MAX_PARALLEL-1:0] maskedErr;
  logic [WD_W-1:0]         wd;
  logic                    vecErr;
  logic                    timeoutSeen;
  logic                    doneHit;
  logic                    timeoutHit;
  logic                    lastVec;

  assign clampedCount =
    (vector_count > VEC_W'(MAX_VECTORS)) ?
    VEC_W'(MAX_VECTORS) : vector_count;
  assign maskedErr  = tbl.lane_error & activeMask;
  assign doneHit    = |(tbl.lane_done & activeMask);
  assign timeoutHit = (TIMEOUT_CYCLES != 0) &&
                      (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign lastVec    = (vector_idx == cnt - VEC_W'(1));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= Idle;
    else           state <= nextState;
  end

  always_comb begin
    nextState       = state;
    tbl.tbl_rd_en   = 1'b0;
    tbl.tbl_rd_addr = vector_idx;
    tbl.lane_start  = '0;
    tbl.lane_abort  = '0;
    vector_done     = 1'b0;
    vector_err      = 1'b0;
    unique case (state)
      Idle: begin
        if (start)
          nextState = (clampedCount == '0) ? Done : Fetch;
      end
      Fetch: begin
        tbl.tbl_rd_en = 1'b1;
        nextState     = WaitRd;
      end
      WaitRd: nextState = Launch;
      Launch: begin
        tbl.lane_start = activeMask;
        nextState = (activeMask == '0) ? Drain : Run;
      end
      Run: begin
        if (doneHit || timeoutHit) nextState = Drain;
      end
      Drain: begin
        tbl.lane_abort = activeMask & ~finished;
        vector_done    = 1'b1;
        vector_err     = vecErr;
        nextState      = lastVec ? Done : Fetch;
      end
      Done:    nextState = Idle;
      default: nextState = Idle;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      busy        <= 1'b0;
      vector_idx  <= '0;
      suite_done  <= 1'b0;
      suite_pass  <= 1'b0;
      error_lanes <= '0;
      cnt         <= '0;
      activeMask  <= '0;
      finished    <= '0;
      wd          <= '0;
      vecErr      <= 1'b0;
      timeoutSeen <= 1'b0;
    end else begin
      suite_done <= (state == Done);
      unique case (state)
        Idle: begin
          if (start) begin
            busy        <= 1'b1;
            vector_idx  <= '0;
            error_lanes <= '0;
            suite_pass  <= 1'b0;
            timeoutSeen <= 1'b0;
            cnt         <= clampedCount;
          end
        end
        WaitRd: begin
          activeMask <= tbl.tbl_rd_data;
          wd         <= '0;
        end
        Launch: begin
          finished <= '0;
          vecErr   <= 1'b0;
          wd       <= wd + WD_W'(1);
        end
        Run: begin
          wd          <= wd + WD_W'(1);
          error_lanes <= error_lanes | maskedErr;
          if (|maskedErr) vecErr <= 1'b1;
          // Every masked lane reporting done this cycle counts as finished.
          if (doneHit) begin
            finished <= tbl.lane_done & activeMask;
          end else if (timeoutHit) begin
            vecErr      <= 1'b1;
            timeoutSeen <= 1'b1;
          end
        end
        Drain: begin
          activeMask <= '0;
          if (!lastVec) vector_idx <= vector_idx + VEC_W'(1);
        end
        Done: begin
          busy       <= 1'b0;
          suite_pass <= ~|error_lanes & ~timeoutSeen;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_scheduler.sv
// Directed bench for vector_scheduler with a 1-cycle-latency table model.
// Checks are immediate assertions counted into a final summary.
module tb_vector_scheduler;

  localparam int MP = 4;
  localparam int VW = 5;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          start;
  logic [VW-1:0] vector_count;
  logic          busy;
  logic          vector_done;
  logic [VW-1:0] vector_idx;
  logic          vector_err;
  logic          suite_done;
  logic          suite_pass;
  logic [MP-1:0] error_lanes;

  logic [MP-1:0] mem [0:15];

  int nChecks = 0;
  int nFails  = 0;
  int n;

  vector_scheduler_if #(.MAX_PARALLEL(MP), .VEC_W(VW)) bus ();

  vector_scheduler #(
    .MAX_PARALLEL(MP),
    .MAX_VECTORS(16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .start(start),
    .vector_count(vector_count),
    .tbl(bus),
    .busy(busy),
    .vector_done(vector_done),
    .vector_idx(vector_idx),
    .vector_err(vector_err),
    .suite_done(suite_done),
    .suite_pass(suite_pass),
    .error_lanes(error_lanes)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk)
    if (bus.tbl_rd_en)
      bus.tbl_rd_data <= mem[bus.tbl_rd_addr[3:0]];

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic kick(logic [VW-1:0] c);
    vector_count = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    ap_rst_n = 1'b0;
    start = 1'b0;
    vector_count = '0;
    bus.lane_done = '0;
    bus.lane_error = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) tick();
    chk("reset_outs",
        {busy, vector_done, vector_err, suite_done,
         suite_pass, bus.tbl_rd_en, bus.lane_start,
         bus.lane_abort, error_lanes, vector_idx}, 0);
    ap_rst_n = 1'b1;
    tick();

    // Two vectors: first retires on lane0, second on lane2.
    mem[0] = 4'b0011;
    mem[1] = 4'b0100;
    kick(5'd2);
    chk("t1_fetch0", {busy, bus.tbl_rd_en, bus.tbl_rd_addr},
        {1'b1, 1'b1, 5'd0});
    tick();
    tick();
    chk("t1_start0", bus.lane_start, 4'b0011);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_start_ignored",
        {busy, bus.tbl_rd_en, bus.lane_start, vector_idx},
        {1'b1, 1'b0, 4'b0000, 5'd0});
    repeat (3) tick();
    bus.lane_done = 4'b0001;
    tick();
    bus.lane_done = '0;
    chk("t1_retire0",
        {vector_done, vector_err, vector_idx, bus.lane_abort},
        {1'b1, 1'b0, 5'd0, 4'b0010});
    tick();
    chk("t1_fetch1", {bus.tbl_rd_en, bus.tbl_rd_addr},
        {1'b1, 5'd1});
    tick();
    tick();
    chk("t1_start1", bus.lane_start, 4'b0100);
    tick();
    bus.lane_done = 4'b0100;
    tick();
    bus.lane_done = '0;
    chk("t1_retire1",
        {vector_done, vector_err, vector_idx, bus.lane_abort},
        {1'b1, 1'b0, 5'd1, 4'b0000});
    tick();
    chk("t1_done_state", {suite_done, busy}, 2'b01);
    tick();
    chk("t1_suite", {suite_done, suite_pass, busy}, 3'b110);
    tick();
    chk("t1_pass_held", {suite_done, suite_pass}, 2'b01);

    // All lanes, error on lane3 then lane1 done.
    mem[0] = 4'b1111;
    kick(5'd1);
    tick();
    tick();
    chk("t2_start", bus.lane_start, 4'b1111);
    tick();
    bus.lane_error = 4'b1000;
    tick();
    bus.lane_error = '0;
    chk("t2_err_latch", error_lanes, 4'b1000);
    bus.lane_done = 4'b0010;
    tick();
    bus.lane_done = '0;
    chk("t2_retire",
        {vector_done, vector_err, bus.lane_abort},
        {1'b1, 1'b1, 4'b1101});
    tick();
    tick();
    chk("t2_suite", {suite_done, suite_pass, error_lanes},
        {1'b1, 1'b0, 4'b1000});

    // Watchdog: lane0 never finishes.
    mem[0] = 4'b0001;
    kick(5'd1);
    chk("t3_clear_err", {error_lanes, suite_pass}, 5'b0);
    tick();
    tick();
    chk("t3_start", bus.lane_start, 4'b0001);
    n = 0;
    while (!vector_done && n < 40) begin
      tick();
      n++;
    end
    chk("t3_latency", n, 16);
    chk("t3_retire", {vector_err, bus.lane_abort},
        {1'b1, 4'b0001});
    tick();
    tick();
    chk("t3_suite", {suite_done, suite_pass}, 2'b10);

    // Empty suite.
    kick(5'd0);
    chk("t4_no_fetch",
        {busy, bus.tbl_rd_en, bus.lane_start, suite_done},
        {1'b1, 1'b0, 4'b0000, 1'b0});
    tick();
    chk("t4_suite", {suite_done, suite_pass, busy}, 3'b110);

    // Vector with empty mask.
    mem[0] = 4'b0000;
    kick(5'd1);
    chk("t5_pass_clr", suite_pass, 1'b0);
    tick();
    tick();
    chk("t5_no_start", bus.lane_start, 4'b0000);
    tick();
    chk("t5_retire",
        {vector_done, vector_err, bus.lane_abort},
        {1'b1, 1'b0, 4'b0000});
    tick();
    tick();
    chk("t5_suite", {suite_done, suite_pass}, 2'b11);

    // Simultaneous done; error on inactive lane ignored.
    mem[0] = 4'b0101;
    kick(5'd1);
    tick();
    tick();
    tick();
    bus.lane_error = 4'b0010;
    tick();
    bus.lane_error = '0;
    chk("t6_inactive_err", error_lanes, 4'b0000);
    bus.lane_done = 4'b0101;
    tick();
    bus.lane_done = '0;
    chk("t6_retire",
        {vector_done, vector_err, bus.lane_abort},
        {1'b1, 1'b0, 4'b0000});
    tick();
    chk("t6_single", vector_done, 1'b0);
    tick();
    chk("t6_suite", {suite_done, suite_pass}, 2'b11);

    // Reset while running the second vector.
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    kick(5'd2);
    tick();
    tick();
    tick();
    bus.lane_done = 4'b0001;
    tick();
    bus.lane_done = '0;
    repeat (4) tick();
    bus.lane_error = 4'b0010;
    tick();
    bus.lane_error = '0;
    chk("t7_pre_reset", {vector_idx, error_lanes, busy},
        {5'd1, 4'b0010, 1'b1});
    ap_rst_n = 1'b0;
    #1;
    chk("t7_async_reset",
        {busy, vector_done, vector_err, suite_done,
         suite_pass, bus.tbl_rd_en, bus.lane_start,
         bus.lane_abort, error_lanes, vector_idx}, 0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    chk("t7_idle", {busy, bus.lane_abort}, 0);

    // Clean run after reset.
    mem[0] = 4'b0010;
    kick(5'd1);
    tick();
    tick();
    chk("t8_start", bus.lane_start, 4'b0010);
    tick();
    bus.lane_done = 4'b0010;
    tick();
    bus.lane_done = '0;
    chk("t8_retire", {vector_done, vector_err, vector_idx},
        {1'b1, 1'b0, 5'd0});
    tick();
    tick();
    chk("t8_suite", {suite_done, suite_pass, busy}, 3'b110);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
